// File: rtl/sp1_ram_pkg.sv
// Shared SP1 RAM constants and request decode.
// Holds the address/data widths, depth and reset data value used by the
// load/store working memory, plus the request classification helper.
package sp1_ram_pkg;

    // RAM geometry shared across the SP1 core.
    localparam int unsigned SP1_RAM_AW    = 6;
    localparam int unsigned SP1_RAM_DW    = 32;
    localparam int unsigned SP1_RAM_DEPTH = 1 << SP1_RAM_AW;

    // Value loaded into dout (and, optionally, memory) on reset.
    localparam logic [31:0] SP1_RAM_RST_DATA = 32'h0000_0000;

    // One request per clock; reset outranks everything else.
    typedef enum logic [1:0] {
        ReqIdle,
        ReqRead,
        ReqWrite,
        ReqReset
    } req_e;

    // Classify the current cycle. cs is tested before we so that an
    // unknown we/adr/din on an idle cycle never reaches the storage.
    function automatic req_e decode_req(input logic rst, input logic cs, input logic we);
        req_e req;
        if (rst) begin
            req = ReqReset;
        end else if (!cs) begin
            req = ReqIdle;
        end else if (we) begin
            req = ReqWrite;
        end else begin
            req = ReqRead;
        end
        return req;
    endfunction

endpackage

// File: rtl/sp1_ram_core.sv
// Bare storage array for the SP1 data RAM: one synchronous write port and a
// registered read port sharing a single address. All control decisions
// (request decode, reset priority) are made by the wrapper.
module sp1_ram_core #(
    parameter int unsigned     AW     = 6,
    parameter int unsigned     DW     = 32,
    parameter logic [DW-1:0]   RstVal = '0
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          dout_clr,
    input  logic          mem_clr,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];

    // Storage update: bulk clear wins over a single-word write.
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[AW'(i)] <= RstVal;
            end
        end else if (wr_en) begin
            mem[adr] <= din;
        end
    end

    // Read register: holds its value across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (dout_clr) begin
            dout <= RstVal;
        end else if (rd_en) begin
            dout <= mem[adr];
        end
    end

endmodule

// File: rtl/sp1_ram.sv
// SP1 single-port data RAM, 2^AW words of DW bits, one access per clock.
// Decodes cs/we into a read or write for the storage core and gives a
// synchronous active-high reset priority over any request.
// Build option: define SP1_RAM_RESET_CLEAR_EN to also zero every memory word
// on a reset edge; by default only dout is reset and memory is left intact.
module sp1_ram
    import sp1_ram_pkg::*;
#(
    parameter int unsigned AW = SP1_RAM_AW,
    parameter int unsigned DW = SP1_RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    req_e req;
    logic wr_en;
    logic rd_en;
    logic dout_clr;
    logic mem_clr;

    // Classify this cycle's request.
    always_comb begin
        req = decode_req(rst, cs, we);
    end

    // Turn the request into core strobes; idle leaves everything untouched.
    always_comb begin
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        dout_clr = 1'b0;
        unique case (req)
            ReqIdle:  ;
            ReqRead:  rd_en = 1'b1;
            ReqWrite: wr_en = 1'b1;
            ReqReset: dout_clr = 1'b1;
            default:  ;
        endcase
    end

    // Memory clear follows reset only in the clearing build.
`ifdef SP1_RAM_RESET_CLEAR_EN
    always_comb begin
        mem_clr = dout_clr;
    end
`else
    always_comb begin
        mem_clr = 1'b0;
    end
`endif

    sp1_ram_core #(
        .AW     (AW),
        .DW     (DW),
        .RstVal (DW'(SP1_RAM_RST_DATA))
    ) u_core (
        .clk      (clk),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .dout_clr (dout_clr),
        .mem_clr  (mem_clr),
        .adr      (adr),
        .din      (din),
        .dout     (dout)
    );

endmodule

// File: tb/tb_sp1_ram.sv
// Self-checking bench for sp1_ram: directed vector table for the named
// corner cases, then random traffic checked against an array-based model.
module tb_sp1_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs  = 1'b0;
    logic        we  = 1'b0;
    logic [5:0]  adr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;

    int total = 0;
    int bad   = 0;

    // Reference model: word array with a known flag per word (memory starts
    // unknown unless a clearing reset has happened).
    logic [31:0] m_mem   [64];
    bit          m_known [64];
    logic [31:0] m_dout;
    bit          m_dout_known = 1'b0;

`ifdef SP1_RAM_RESET_CLEAR_EN
    localparam logic [31:0] RstReadExp = 32'h0000_0000;
`else
    localparam logic [31:0] RstReadExp = 32'h0BAD_C0DE;
`endif

    typedef struct {
        logic        rst;
        logic        cs;
        logic        we;
        logic [5:0]  adr;
        logic [31:0] din;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    sp1_ram #(
        .AW (6),
        .DW (32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .adr  (adr),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dout=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic w,
                                input logic [5:0] a, input logic [31:0] d);
        if (r === 1'b1) begin
            m_dout       = 32'h0;
            m_dout_known = 1'b1;
`ifdef SP1_RAM_RESET_CLEAR_EN
            for (int i = 0; i < 64; i++) begin
                m_mem[i]   = 32'h0;
                m_known[i] = 1'b1;
            end
`endif
        end else if (c === 1'b1) begin
            if (w === 1'b1) begin
                m_mem[a]   = d;
                m_known[a] = 1'b1;
            end else if (m_known[a]) begin
                m_dout       = m_mem[a];
                m_dout_known = 1'b1;
            end else begin
                m_dout_known = 1'b0;
            end
        end
    endtask

    // Drive one cycle away from the edge, then compare after the edge.
    task automatic step(input logic r, input logic c, input logic w,
                        input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        cs  = c;
        we  = w;
        adr = a;
        din = d;
        @(posedge clk);
        #1;
        model_update(r, c, w, a, d);
        if (m_dout_known) check("model", dout, m_dout);
    endtask

    function automatic vec_t mk(input logic r, input logic c, input logic w,
                                input logic [5:0] a, input logic [31:0] d,
                                input bit chk, input logic [31:0] exp);
        vec_t v;
        v.rst = r;
        v.cs  = c;
        v.we  = w;
        v.adr = a;
        v.din = d;
        v.chk = chk;
        v.exp = exp;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;

        // Reset held for three edges with cs low.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 'x, 'x, 'x, 1, 32'h0));
        tbl.push_back(mk(0, 0, 'x, 'x, 'x, 1, 32'h0));
        // Write then read; the write alone must not move dout.
        tbl.push_back(mk(0, 1, 1, 6'h05, 32'hDEADBEEF, 1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 6'h05, 'x, 1, 32'hDEADBEEF));
        // Lowest and highest address, no aliasing.
        tbl.push_back(mk(0, 1, 1, 6'h00, 32'h11111111, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 1, 6'h3F, 32'h22222222, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 0, 6'h00, 'x, 1, 32'h11111111));
        tbl.push_back(mk(0, 1, 0, 6'h3F, 'x, 1, 32'h22222222));
        // Hold across idle cycles with unknown inputs, then re-read.
        tbl.push_back(mk(0, 1, 1, 6'h10, 32'hA5A5A5A5, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 6'h10, 'x, 1, 32'hA5A5A5A5));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 'x, 'x, 'x, 1, 32'hA5A5A5A5));
        tbl.push_back(mk(0, 1, 0, 6'h10, 'x, 1, 32'hA5A5A5A5));
        // Write after read leaves dout alone; back-to-back read sees new data.
        tbl.push_back(mk(0, 1, 0, 6'h05, 'x, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 1, 6'h06, 32'h12345678, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 0, 6'h06, 'x, 1, 32'h12345678));
        // Reset in the same cycle as a write cancels it.
        tbl.push_back(mk(0, 1, 1, 6'h07, 32'h0BADC0DE, 1, 32'h12345678));
        tbl.push_back(mk(1, 1, 1, 6'h07, 32'hCAFEF00D, 1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 6'h07, 'x, 1, RstReadExp));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].cs, tbl[i].we, tbl[i].adr, tbl[i].din);
            if (tbl[i].chk) check($sformatf("vec%0d", i), dout, tbl[i].exp);
        end

        // Random traffic, biased to a few addresses so reads hit written words.
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic       c;
            logic       w;
            logic [5:0] a;
            r = ($urandom_range(0, 59) == 0);
            c = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            step(r, c, w, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
